// File: rtl/pov_spi_master_pkg.sv
// ----------------------------------------------------------------------------
// pov_spi_master_pkg
// Shared constants and the FSM state type for the view-vector SPI master.
//   POV_FIXED_BITS  - fixed-point word width used for every view vector
//   POV_VALUE_COUNT - number of vector components in one frame
//   pov_state_e     - transmitter FSM states
// ----------------------------------------------------------------------------
package pov_spi_master_pkg;

    localparam int POV_FIXED_BITS  = 20;
    localparam int POV_VALUE_COUNT = 6;

    localparam logic [2:0] POV_ST_IDLE  = 3'd0;
    localparam logic [2:0] POV_ST_LEAD  = 3'd1;
    localparam logic [2:0] POV_ST_SHIFT = 3'd2;
    localparam logic [2:0] POV_ST_TRAIL = 3'd3;
    localparam logic [2:0] POV_ST_GAP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = POV_ST_IDLE,
        ST_LEAD  = POV_ST_LEAD,
        ST_SHIFT = POV_ST_SHIFT,
        ST_TRAIL = POV_ST_TRAIL,
        ST_GAP   = POV_ST_GAP
    } pov_state_e;

endpackage

// File: rtl/pov_spi_master_timer.sv
// ----------------------------------------------------------------------------
// spi_half_period_timer
// Counts 0..CLK_DIV-1 and flags the last count of each SPI half period.
//   clk       in  system clock
//   reset     in  synchronous, active-high reset
//   i_restart in  hold the counter at zero (asserted while the FSM is idle)
//   o_tick    out high during the final cycle of a half period
// ----------------------------------------------------------------------------
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Every FSM transition happens on a tick, so the natural wrap to zero
    // doubles as the restart on each state entry after LEAD.
    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pov_spi_master.sv
// ----------------------------------------------------------------------------
// pov_spi_master
// Serialises six view vectors into one framed SPI mode-0 transaction:
// playerX, playerY, facingX, facingY, vplaneX, vplaneY, each MSB first.
//   clk            in  system clock
//   reset          in  synchronous, active-high reset
//   i_start        in  send request, sampled only while idle
//   i_frame_tick   in  auto-send trigger (only with POV_SPI_AUTO_EN)
//   i_playerX..i_vplaneY in  vector components, latched on accepted start
//   o_busy         out frame in progress
//   o_done         out one-cycle pulse at the end of the inter-frame gap
//   o_sclk         out SPI clock, idles low
//   o_mosi         out SPI data
//   o_ss_n         out active-low slave select
// Optional feature macro: POV_SPI_AUTO_EN (frame-tick triggered sends with a
// single collapsed pending request while busy).
// ----------------------------------------------------------------------------
module pov_spi_master
    import pov_spi_master_pkg::*;
#(
    parameter int VALUE_BITS = POV_FIXED_BITS,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
`ifdef POV_SPI_AUTO_EN
    input  logic                  i_frame_tick,
`endif
    input  logic [VALUE_BITS-1:0] i_playerX,
    input  logic [VALUE_BITS-1:0] i_playerY,
    input  logic [VALUE_BITS-1:0] i_facingX,
    input  logic [VALUE_BITS-1:0] i_facingY,
    input  logic [VALUE_BITS-1:0] i_vplaneX,
    input  logic [VALUE_BITS-1:0] i_vplaneY,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_sclk,
    output logic                  o_mosi,
    output logic                  o_ss_n
);

    localparam int N   = POV_VALUE_COUNT * VALUE_BITS;
    localparam int BCW = $clog2(N + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(N - 1);

    pov_state_e     r_state;
    logic [N-1:0]   r_shift;
    logic [BCW-1:0] r_bit_cnt;
    logic           r_phase;   // 0: low half of a bit, 1: high half
    logic           r_busy;
    logic           r_done;
    logic           r_sclk;
    logic           r_mosi;
    logic           r_ss_n;

    logic           w_tick;
    logic           w_restart;
    logic           w_go;
    logic [N-1:0]   w_frame;

    assign w_frame   = {i_playerX, i_playerY, i_facingX, i_facingY, i_vplaneX, i_vplaneY};
    assign w_restart = (r_state == ST_IDLE);

`ifdef POV_SPI_AUTO_EN
    logic r_pending;
    assign w_go = i_start | i_frame_tick | r_pending;
`else
    assign w_go = i_start;
`endif

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            // NOTE: the shift register is reset too; it is a single datapath
            // register, not a memory array, and clearing it keeps idle state
            // fully deterministic.
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ss_n    <= 1'b1;
`ifdef POV_SPI_AUTO_EN
            r_pending <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef POV_SPI_AUTO_EN
            // Any number of ticks during a frame collapse into one request.
            if (r_state != ST_IDLE && i_frame_tick) begin
                r_pending <= 1'b1;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_shift   <= w_frame;
                        r_mosi    <= w_frame[N-1];
                        r_ss_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_phase   <= 1'b0;
                        r_state   <= ST_LEAD;
`ifdef POV_SPI_AUTO_EN
                        r_pending <= 1'b0;
`endif
                    end
                end
                ST_LEAD: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (!r_phase) begin
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            // Falling edge: data advances only while sclk is low.
                            r_sclk    <= 1'b0;
                            r_phase   <= 1'b0;
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_mosi  <= 1'b0;
                                r_state <= ST_TRAIL;
                            end else begin
                                r_mosi  <= r_shift[N-2];
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (w_tick) begin
                        r_ss_n  <= 1'b1;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sclk = r_sclk;
    assign o_mosi = r_mosi;
    assign o_ss_n = r_ss_n;

endmodule

// File: tb/tb_pov_spi_master.sv
// ----------------------------------------------------------------------------
// tb_pov_spi_master
// Two instances: dut_s (CLK_DIV=4) for frame content, latency and abort
// scenarios, dut_f (CLK_DIV=1) for back-to-back frames. A negedge SPI slave
// monitor captures frames; expected frames are queued when a start is driven
// and compared when a captured frame appears.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pov_spi_master;

    localparam int VB    = 20;
    localparam int N     = 6 * VB;
    localparam int LAT_S = 4 * (2 * N + 3) + 1;
    localparam int BOUND = 5000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_s = 1'b0;
    logic start_f = 1'b0;
    logic [VB-1:0] px = '0, py = '0, fx = '0, fy = '0, vx = '0, vy = '0;
    logic busy_s, done_s, sclk_s, mosi_s, ss_s;
    logic busy_f, done_f, sclk_f, mosi_f, ss_f;
`ifdef POV_SPI_AUTO_EN
    logic tick_s = 1'b0;
    logic tick_f = 1'b0;
`endif

    always #5 clk = ~clk;

    pov_spi_master #(.VALUE_BITS(VB), .CLK_DIV(4)) dut_s (
        .clk(clk), .reset(reset), .i_start(start_s),
`ifdef POV_SPI_AUTO_EN
        .i_frame_tick(tick_s),
`endif
        .i_playerX(px), .i_playerY(py), .i_facingX(fx), .i_facingY(fy),
        .i_vplaneX(vx), .i_vplaneY(vy),
        .o_busy(busy_s), .o_done(done_s), .o_sclk(sclk_s), .o_mosi(mosi_s), .o_ss_n(ss_s)
    );

    pov_spi_master #(.VALUE_BITS(VB), .CLK_DIV(1)) dut_f (
        .clk(clk), .reset(reset), .i_start(start_f),
`ifdef POV_SPI_AUTO_EN
        .i_frame_tick(tick_f),
`endif
        .i_playerX(px), .i_playerY(py), .i_facingX(fx), .i_facingY(fy),
        .i_vplaneX(vx), .i_vplaneY(vy),
        .o_busy(busy_f), .o_done(done_f), .o_sclk(sclk_f), .o_mosi(mosi_f), .o_ss_n(ss_f)
    );

    // ---------------- SPI slave monitor (index 0: dut_s, 1: dut_f) ----------
    logic m_ss[2], m_sclk[2], m_mosi[2], m_done[2];
    assign m_ss[0] = ss_s;   assign m_ss[1] = ss_f;
    assign m_sclk[0] = sclk_s; assign m_sclk[1] = sclk_f;
    assign m_mosi[0] = mosi_s; assign m_mosi[1] = mosi_f;
    assign m_done[0] = done_s; assign m_done[1] = done_f;

    logic         p_ss[2]       = '{1'b1, 1'b1};
    logic         p_sclk[2]     = '{1'b0, 1'b0};
    logic         p_mosi[2]     = '{1'b0, 1'b0};
    logic         m_active[2]   = '{1'b0, 1'b0};
    logic         m_had_frame[2] = '{1'b0, 1'b0};
    logic [N-1:0] m_cur[2];
    int           m_cur_cnt[2]  = '{0, 0};
    int           m_done_cnt[2] = '{0, 0};
    int           m_rise_tot[2] = '{0, 0};
    int           m_gap_run[2]  = '{0, 0};
    int           m_min_gap[2]  = '{1000000, 1000000};
    int           m_mosi_bad[2] = '{0, 0};
    logic [N-1:0] cap_data[2][16];
    int           cap_len[2][16];
    int           cap_wr[2]     = '{0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            p_ss[i]   <= m_ss[i];
            p_sclk[i] <= m_sclk[i];
            p_mosi[i] <= m_mosi[i];
            if (m_done[i]) m_done_cnt[i] <= m_done_cnt[i] + 1;
            if (m_sclk[i] && !p_sclk[i]) m_rise_tot[i] <= m_rise_tot[i] + 1;
            if (reset) begin
                m_active[i]  <= 1'b0;
                m_cur_cnt[i] <= 0;
            end else begin
                if (p_ss[i] && !m_ss[i]) begin
                    m_active[i]  <= 1'b1;
                    m_cur_cnt[i] <= 0;
                    m_cur[i]     <= '0;
                    m_gap_run[i] <= 0;
                    if (m_had_frame[i] && m_gap_run[i] < m_min_gap[i])
                        m_min_gap[i] <= m_gap_run[i];
                end else if (m_ss[i]) begin
                    m_gap_run[i] <= m_gap_run[i] + 1;
                end
                if (!m_ss[i] && m_active[i] && m_sclk[i] && !p_sclk[i]) begin
                    m_cur[i]     <= {m_cur[i][N-2:0], m_mosi[i]};
                    m_cur_cnt[i] <= m_cur_cnt[i] + 1;
                    if (m_mosi[i] !== p_mosi[i]) m_mosi_bad[i] <= m_mosi_bad[i] + 1;
                end
                if (!p_ss[i] && m_ss[i] && m_active[i]) begin
                    cap_data[i][cap_wr[i] % 16] <= m_cur[i];
                    cap_len[i][cap_wr[i] % 16]  <= m_cur_cnt[i];
                    cap_wr[i]      <= cap_wr[i] + 1;
                    m_active[i]    <= 1'b0;
                    m_had_frame[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [N-1:0] exp_q0[$];
    logic [N-1:0] exp_q1[$];
    int sb_rd[2] = '{0, 0};
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [N-1:0] cur_frame();
        return {px, py, fx, fy, vx, vy};
    endfunction

    task automatic scoreboard_drain(input int idx, input string tag);
        logic [N-1:0] exp;
        logic [N-1:0] got;
        int len;
        int left;
        while (sb_rd[idx] < cap_wr[idx]) begin
            got = cap_data[idx][sb_rd[idx] % 16];
            len = cap_len[idx][sb_rd[idx] % 16];
            sb_rd[idx]++;
            left = (idx == 0) ? exp_q0.size() : exp_q1.size();
            n_checks++;
            if (left == 0) begin
                n_errors++;
                $display("FAIL %s unexpected_frame got=%h expected=none", tag, got);
            end else begin
                exp = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                n_checks++;
                if (len !== N) begin
                    n_errors++;
                    $display("FAIL %s frame_bits got=%0d expected=%0d", tag, len, N);
                end
                n_checks++;
                if (got !== exp) begin
                    n_errors++;
                    $display("FAIL %s frame_data got=%h expected=%h", tag, got, exp);
                end
            end
        end
        left = (idx == 0) ? exp_q0.size() : exp_q1.size();
        n_checks++;
        if (left !== 0) begin
            n_errors++;
            $display("FAIL %s missing_frames got=0 expected=%0d", tag, left);
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Drives a one-cycle start on dut_s and waits for o_done. Optionally alters
    // the inputs right after acceptance, or re-pulses start at a given bit.
    task automatic run_frame(input bit alter, input int poke_bit,
                             output int latency, output logic busy_after, output logic busy_at_done);
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        latency = 1;
        busy_after = busy_s;
        if (alter) begin
            px = ~px; py = ~py; fx = ~fx; fy = ~fy; vx = ~vx; vy = ~vy;
        end
        if (poke_bit >= 0) begin
            while (m_cur_cnt[0] < poke_bit && latency < BOUND) begin
                @(posedge clk); #1; latency++;
            end
            start_s = 1'b1;
            @(posedge clk); #1; latency++;
            start_s = 1'b0;
        end
        while (!done_s && latency < BOUND) begin
            @(posedge clk); #1; latency++;
        end
        busy_at_done = busy_s;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        int bad;
        int rise0;
        reset = 1'b1;
        idle_cycles(5);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({ss_s, sclk_s, mosi_s, busy_s, done_s} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_outputs_s got=%b expected=10000", {ss_s, sclk_s, mosi_s, busy_s, done_s});
        end
        n_checks++;
        if ({ss_f, sclk_f, mosi_f, busy_f, done_f} !== 5'b10000) begin
            n_errors++;
            $display("FAIL reset_outputs_f got=%b expected=10000", {ss_f, sclk_f, mosi_f, busy_f, done_f});
        end
        bad = 0;
        rise0 = m_rise_tot[0];
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (ss_s !== 1'b1 || sclk_s !== 1'b0 || busy_s !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_errors++;
            $display("FAIL idle_hold bad_cycles got=%0d expected=0", bad);
        end
        n_checks++;
        if (m_rise_tot[0] - rise0 !== 0) begin
            n_errors++;
            $display("FAIL idle_sclk_edges got=%0d expected=0", m_rise_tot[0] - rise0);
        end
    endtask

    task automatic test_single_frame;
        int lat;
        logic b1, bd;
        int done0;
        px = 20'h12345; py = 20'h0ABCD; fx = 20'hFFFFF;
        fy = 20'h00000; vx = 20'h80000; vy = 20'h00001;
        exp_q0.push_back(cur_frame());
        done0 = m_done_cnt[0];
        run_frame(1'b0, -1, lat, b1, bd);
        n_checks++;
        if (lat !== LAT_S) begin
            n_errors++;
            $display("FAIL single_latency got=%0d expected=%0d", lat, LAT_S);
        end
        n_checks++;
        if (b1 !== 1'b1) begin
            n_errors++;
            $display("FAIL single_busy_after_start got=%b expected=1", b1);
        end
        n_checks++;
        if (bd !== 1'b0) begin
            n_errors++;
            $display("FAIL single_busy_at_done got=%b expected=0", bd);
        end
        idle_cycles(20);
        n_checks++;
        if (m_done_cnt[0] - done0 !== 1) begin
            n_errors++;
            $display("FAIL single_done_count got=%0d expected=1", m_done_cnt[0] - done0);
        end
        scoreboard_drain(0, "single");
    endtask

    task automatic test_input_change;
        int lat;
        logic b1, bd;
        px = 20'hA5A5A; py = 20'h5A5A5; fx = 20'h00F0F;
        fy = 20'hF0F00; vx = 20'h13579; vy = 20'h2468A;
        exp_q0.push_back(cur_frame());
        run_frame(1'b1, -1, lat, b1, bd);
        n_checks++;
        if (lat !== LAT_S) begin
            n_errors++;
            $display("FAIL input_change_latency got=%0d expected=%0d", lat, LAT_S);
        end
        idle_cycles(20);
        scoreboard_drain(0, "input_change");
    endtask

    task automatic test_start_while_busy;
        int lat;
        logic b1, bd;
        int done0, cap0;
        px = $urandom(); py = $urandom(); fx = $urandom();
        fy = $urandom(); vx = $urandom(); vy = $urandom();
        exp_q0.push_back(cur_frame());
        done0 = m_done_cnt[0];
        cap0 = cap_wr[0];
        run_frame(1'b0, 37, lat, b1, bd);
        idle_cycles(1200);
        n_checks++;
        if (m_done_cnt[0] - done0 !== 1) begin
            n_errors++;
            $display("FAIL busy_start_done_count got=%0d expected=1", m_done_cnt[0] - done0);
        end
        n_checks++;
        if (cap_wr[0] - cap0 !== 1) begin
            n_errors++;
            $display("FAIL busy_start_frame_count got=%0d expected=1", cap_wr[0] - cap0);
        end
        scoreboard_drain(0, "busy_start");
    endtask

    task automatic test_reset_mid_frame;
        int w;
        int done0, cap0, lat;
        logic b1, bd;
        px = 20'h0F0F0; py = 20'h11111; fx = 20'h22222;
        fy = 20'h33333; vx = 20'h44444; vy = 20'h55555;
        done0 = m_done_cnt[0];
        cap0 = cap_wr[0];
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        w = 0;
        while (m_cur_cnt[0] < 60 && w < BOUND) begin
            @(negedge clk); w++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ss_s, sclk_s, busy_s} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_mid_outputs got=%b expected=100", {ss_s, sclk_s, busy_s});
        end
        idle_cycles(1);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(50);
        n_checks++;
        if (m_done_cnt[0] - done0 !== 0 || cap_wr[0] - cap0 !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_no_done got=%0d/%0d expected=0/0", m_done_cnt[0] - done0, cap_wr[0] - cap0);
        end
        exp_q0.push_back(cur_frame());
        run_frame(1'b0, -1, lat, b1, bd);
        n_checks++;
        if (lat !== LAT_S) begin
            n_errors++;
            $display("FAIL reset_mid_restart_latency got=%0d expected=%0d", lat, LAT_S);
        end
        idle_cycles(20);
        scoreboard_drain(0, "reset_mid");
    endtask

    task automatic test_back_to_back;
        int dones, cyc, cap0;
        px = 20'hCAFE1; py = 20'hBEEF2; fx = 20'h0DEAD;
        fy = 20'hFACE3; vx = 20'h7777F; vy = 20'h80808;
        cap0 = cap_wr[1];
        for (int k = 0; k < 3; k++) exp_q1.push_back(cur_frame());
        @(negedge clk);
        start_f = 1'b1;
        dones = 0;
        cyc = 0;
        while (dones < 3 && cyc < BOUND) begin
            @(posedge clk); #1; cyc++;
            if (done_f) dones++;
        end
        start_f = 1'b0;
        idle_cycles(300);
        n_checks++;
        if (dones !== 3) begin
            n_errors++;
            $display("FAIL b2b_done_count got=%0d expected=3", dones);
        end
        n_checks++;
        if (cap_wr[1] - cap0 !== 3) begin
            n_errors++;
            $display("FAIL b2b_frame_count got=%0d expected=3", cap_wr[1] - cap0);
        end
        n_checks++;
        if (m_min_gap[1] !== 2) begin
            n_errors++;
            $display("FAIL b2b_ss_gap got=%0d expected=2", m_min_gap[1]);
        end
        n_checks++;
        if (m_mosi_bad[0] + m_mosi_bad[1] !== 0) begin
            n_errors++;
            $display("FAIL mosi_at_rise changes got=%0d expected=0", m_mosi_bad[0] + m_mosi_bad[1]);
        end
        scoreboard_drain(1, "b2b");
    endtask

`ifdef POV_SPI_AUTO_EN
    task automatic test_auto_tick;
        int dones, cyc;
        px = 20'h31415; py = 20'h92653; fx = 20'h58979;
        fy = 20'h32384; vx = 20'h62643; vy = 20'h38327;
        exp_q0.push_back(cur_frame());
        exp_q0.push_back(cur_frame());
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (100) @(negedge clk);
            tick_s = 1'b1;
            @(negedge clk);
            tick_s = 1'b0;
        end
        dones = 0;
        cyc = 0;
        while (cyc < 3500) begin
            @(posedge clk); #1; cyc++;
            if (done_s) dones++;
        end
        n_checks++;
        if (dones !== 2) begin
            n_errors++;
            $display("FAIL auto_tick_done_count got=%0d expected=2", dones);
        end
        scoreboard_drain(0, "auto_tick");
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_input_change();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef POV_SPI_AUTO_EN
        test_auto_tick();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
